// File: rtl/systolic_result_collector.sv
// systolic_result_collector: de-skews the N skewed activation lanes of the
// systolic array into an N*N row-major result store and exposes that store
// through a registered read port with busy/done/overrun status.
// Lane j carries element e of row j at capture step k = j + e, so one generic
// step counter decides which lanes are live instead of per-cycle write-back.
module systolic_result_collector #(
  parameter int DW = 8,
  parameter int N  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      clr,
  input  logic [N*DW-1:0]           lane_in,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun,
  input  logic                      rd_en,
  input  logic [$clog2(N*N)-1:0]    rd_addr,
  output logic [DW-1:0]             rd_data,
  output logic                      rd_valid
);

  localparam int DEPTH     = N * N;
  localparam int LAST_STEP = 2 * N - 2;
  localparam int SW        = $clog2(2 * N - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            overrun_q, overrun_d;
  logic            rd_valid_q, rd_valid_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic [DW-1:0]   store_q [DEPTH];
  logic [DW-1:0]   store_d [DEPTH];
  logic            cap_en_s;

  // Capture sequencer: state, step counter and status flags; clr wins over start.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    busy_d    = busy_q;
    done_d    = done_q;
    overrun_d = overrun_q;
    cap_en_s  = 1'b0;
    if (clr) begin
      state_d   = ST_IDLE;
      step_d    = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // step_q is always 0 here, so the start cycle writes step 0.
          if (start) begin
            cap_en_s = 1'b1;
            state_d  = ST_CAPTURE;
            step_d   = SW'(1);
            busy_d   = 1'b1;
            done_d   = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        ST_CAPTURE: begin
          cap_en_s = 1'b1;
          if (start) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
          if (step_q == SW'(LAST_STEP)) begin
            state_d = ST_DONE;
            step_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          step_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // Store write-back: lane j lands in row j, column (step - j) when in range.
  always_comb begin
    store_d = store_q;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        store_d[i] = '0;
      end
    end else if (cap_en_s) begin
      for (int j = 0; j < N; j++) begin
        for (int e = 0; e < N; e++) begin
          if (int'(step_q) == j + e) begin
            store_d[j*N + e] = lane_in[j*DW +: DW];
          end else begin
            store_d[j*N + e] = store_q[j*N + e];
          end
        end
      end
    end else begin
      store_d = store_q;
    end
  end

  // Read port: honoured only while a complete capture is held; data holds otherwise.
  always_comb begin
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (!clr && rd_en && (state_q == ST_DONE)) begin
      rd_valid_d = 1'b1;
      rd_data_d  = store_q[rd_addr];
    end else begin
      rd_valid_d = 1'b0;
    end
  end

  // State, status, read and store registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        store_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      for (int i = 0; i < DEPTH; i++) begin
        store_q[i] <= store_d[i];
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = overrun_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule
